// File: rtl/act_skew_feeder.sv
// Skews activation vectors into a systolic array: row r delays its element by r
// extra cycles so the diagonal wavefront lines up with the PE grid.
module act_skew_feeder #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_data,
  input  logic                         in_last,
  output logic [ROWS*DATA_WIDTH-1:0]   row_data,
  output logic [ROWS-1:0]              row_valid,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [ROWS-1:0]   valid_next;
  logic [ROWS-1:0]   tag_q;

  assign accept = in_valid & in_ready;

  // State register; in_ready and busy are registered from the next-state view.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != DRAIN);
      busy     <= (state_next != IDLE) | (|valid_next);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = in_last ? DRAIN : STREAM;
      end
      STREAM: begin
        if (accept && in_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Last-tag rides alongside the element bound for row ROWS-1; its tail is done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= accept & in_last;
      for (int i = 1; i < int'(ROWS); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign done = tag_q[ROWS-1];

  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    localparam int unsigned DEPTH = r + 1;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    // Bubbles inject zero data, so idle slots are always all-zero.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < int'(DEPTH); s++) begin
          data_q[s] <= '0;
        end
        valid_q <= '0;
      end else begin
        data_q[0]  <= accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        valid_q[0] <= accept;
        for (int s = 1; s < int'(DEPTH); s++) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
      end
    end

    assign row_data[r*DATA_WIDTH +: DATA_WIDTH] = data_q[DEPTH-1];
    assign row_valid[r]                         = valid_q[DEPTH-1];

    if (r == 0) begin : g_head
      assign valid_next[r] = accept;
    end else begin : g_tail
      assign valid_next[r] = valid_q[DEPTH-2];
    end
  end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, giving the number of systolic array rows fed (legal range 1-16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the activation element width.
REQ-003 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port in_valid, input, 1 bit: upstream offers one activation vector this cycle.
REQ-006 Port in_ready, output, 1 bit: block accepts a vector this cycle.
REQ-007 Port in_data, input, ROWS*DATA_WIDTH bits: vector; element r at bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port in_last, input, 1 bit: qualifies the final vector of a tile; sampled only on acceptance.
REQ-009 Port row_data, output, ROWS*DATA_WIDTH bits: per-row activation into the PE a_in inputs of column 0, same packing as in_data.
REQ-010 Port row_valid, output, ROWS bits: per-row valid into the PE valid inputs.
REQ-011 Port busy, output, 1 bit: high when FSM not IDLE or any row_valid bit high.
REQ-012 Port done, output, 1 bit: one-cycle pulse when the last vector's final element leaves row ROWS-1.

Function
REQ-013 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both high; nothing else is accepted.
REQ-014 The FSM SHALL have states IDLE, STREAM, DRAIN; in_ready = 1 in IDLE and STREAM, 0 in DRAIN.
REQ-015 Transitions: IDLE->STREAM on acceptance with in_last=0; IDLE or STREAM->DRAIN on acceptance with in_last=1; DRAIN->IDLE on the edge ending the done cycle; otherwise hold.
REQ-016 Row r SHALL be a shift pipeline of depth r+1 that advances every cycle unconditionally (no downstream backpressure).
REQ-017 Element r of a vector accepted at edge k SHALL appear on row_data[r] with row_valid[r]=1 during the cycle after edge k+r (row 0 latency 1, row r latency 1+r).
REQ-018 A cycle without acceptance SHALL inject a bubble: valid 0 and data 0 into every row pipeline.
REQ-019 row_data[r] SHALL be all-zero whenever row_valid[r]=0.
REQ-020 A last-tag bit SHALL travel with element ROWS-1; done = row_valid[ROWS-1] AND tag, registered-path only, no combinational path from in_*.
REQ-021 Back-to-back acceptances in consecutive cycles SHALL produce contiguous row_valid runs with no gaps or duplicates.
REQ-022 in_ready SHALL be 0 from the edge accepting in_last through the done cycle inclusive; a new tile is accepted no earlier than the cycle after done.
REQ-023 For ROWS=1 done SHALL pulse in the cycle after the last acceptance; DRAIN lasts exactly that cycle.
REQ-024 Data SHALL pass unmodified; no arithmetic, no sign interpretation.

Reset
REQ-025 While reset is high, regardless of clock: state = IDLE, all pipeline data and valid/tag bits = 0, row_data = 0, row_valid = 0, done = 0, busy = 0, in_ready = 1.
REQ-026 Reset asserted mid-tile (STREAM or DRAIN) SHALL discard all in-flight elements with no done pulse; operation resumes from IDLE on the first edge after deassertion.

Verification (ROWS=4, DATA_WIDTH=8)
REQ-027 Single vector {0x04,0x03,0x02,0x01} (row3..row0) with in_last at edge 0 -> row_valid = 0001,0010,0100,1000 in cycles 1-4; row_data[r] = r+1 in its cycle; done high in cycle 4 only; in_ready 0 cycles 1-4.
REQ-028 Four back-to-back vectors A,B,C,D (D last) -> row 0 valid cycles 1-4, row 3 valid cycles 4-7 carrying A..D in order; done in cycle 7 only; busy low from cycle 8.
REQ-029 Vectors at edges 0 and 2 (gap at 1, second last) -> each row shows valid, bubble (data 0), valid; done in cycle 6.
REQ-030 in_valid held high during DRAIN with new data -> no acceptance until the cycle after done; new vector enters row 0 one cycle after its acceptance.
REQ-031 Reset pulse at cycle 2 of scenario REQ-028 -> all outputs 0 immediately, no done pulse, in_ready 1; subsequent single-vector tile behaves exactly as REQ-027.
REQ-032 ROWS=1 build, two back-to-back vectors 0x11, 0x22 (second last) -> row_valid 1 in cycles 1-2 with 0x11, 0x22; done in cycle 2 only.
